prbs_random_generator: RTL and testbench
========================================

# prbs_random_generator

Pseudo-random binary sequence (PRBS) source with a programmable bit rate. A 32-bit clock divider produces an advance tick every `user_freq` clock cycles. Each tick steps a maximal-length Fibonacci LFSR and registers one output bit. A one-cycle pulse marks each full sequence rollover. The block feeds stimulus and pattern-test logic that needs a slow, repeatable pseudo-random bit stream.

## Interface
Parameters:
- None. Sequence length is selected by macro (see Configuration).

Ports:
- `clk`  input  1  system clock (100 MHz nominal); single clock domain; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `user_freq`  input  32  divider value: clock cycles per PRBS bit; values 0 and 1 both mean one bit per clock.
- `signal_out`  output  1  registered PRBS bit; reset value 0.
- `signal_cycle`  output  1  registered one-clock rollover pulse; reset value 0.

## Operation
- Divider:
  - `cnt` is a 32-bit counter with reset value 0.
  - `div_max` = 0 if `user_freq` ≤ 1, else `user_freq` − 1.
  - Each edge: if `cnt` ≥ `div_max`, then `cnt` ← 0 and `tick` = 1; else `cnt` ← `cnt` + 1 and `tick` = 0.
  - The `≥` compare means lowering `user_freq` below the current count causes a tick on the next edge. No wrap-around or lock-up is possible.
- LFSR (default PRBS-7, polynomial x^7 + x^6 + 1):
  - 7-bit state `lfsr`, reset value all ones (7'h7F).
  - On `tick`: `signal_out` ← `lfsr[6]`; `fb` = `lfsr[6]` ^ `lfsr[5]`; `lfsr` ← {`lfsr[5:0]`, `fb`}.
  - Without `tick`: `lfsr` and `signal_out` hold.
  - Period is 127 bits: 64 ones and 63 zeros. The all-zero state is unreachable from reset.
  - Lock-up guard: if `lfsr` is ever all zeros, the next tick loads the seed (all ones) instead.
- Rollover:
  - `signal_cycle` ← 1 on a tick whose next `lfsr` value equals the seed.
  - Otherwise `signal_cycle` ← 0, which also clears it on non-tick edges. It is therefore exactly one clock wide.
- `user_freq` is sampled every cycle with no latching; changes take effect immediately through the compare.
- Reset mid-operation: `cnt`, `lfsr`, `signal_out` and `signal_cycle` return to their reset values asynchronously. The sequence restarts from the seed.

## Timing
- After reset deasserts, the first tick occurs on the `user_freq`-th rising edge (the 1st edge if `user_freq` ≤ 1).
- `signal_out` and `signal_cycle` change on the tick edge itself; there is no additional latency.
- Bit period is `max(user_freq, 1)` clocks.
- `signal_cycle` fires on tick 127, 254, … after reset, so the rollover period is 127 × `max(user_freq, 1)` clocks.
- First output bits after reset: seven 1s, then 0.

## Configuration
- `PRBS15_EN` defined:
  - LFSR is 15 bits, polynomial x^15 + x^14 + 1, `fb` = `lfsr[14]` ^ `lfsr[13]`.
  - Seed is all ones; `signal_out` takes `lfsr[14]`.
  - Period is 32767 bits: 16384 ones, 16383 zeros.
  - `signal_cycle` fires every 32767 ticks.
- `PRBS15_EN` undefined: PRBS-7 as described above.
- Divider, ports and reset behaviour are identical in both builds.

## Test plan
- `user_freq` = 1, run 127 clocks after reset:
  - `signal_out` shows 1,1,1,1,1,1,1,0 on the first eight edges.
  - 64 ones counted over the period.
  - One `signal_cycle` pulse, on edge 127.
- `user_freq` = 0 → identical waveform to `user_freq` = 1.
- `user_freq` = 3000, 200 000 clocks after reset → 66 bit updates, 0 `signal_cycle` pulses, `signal_out` constant for 3000 clocks between updates.
- `user_freq` = 3000; at `cnt` ≈ 2000, change `user_freq` to 10:
  - Tick on the next edge.
  - Ticks every 10 clocks thereafter.
- Reset pulse mid-sequence (after tick 50):
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the sequence restarts with seven 1s.
- `PRBS15_EN` build, `user_freq` = 1, 65 534 clocks → `signal_cycle` pulses on edges 32767 and 65534 only.

Source files
------------

// File: rtl/prbs_random_generator.sv
// Divided-rate PRBS source (PRBS-7 x^7+x^6+1; PRBS-15 x^15+x^14+1 when PRBS15_EN is defined).
// The bit and the rollover pulse update on the tick edge itself; there is no handshake and no backpressure.
module prbs_random_generator (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] user_freq,
   output logic        signal_out,
   output logic        signal_cycle
);

`ifdef PRBS15_EN
   localparam int LW = 15;
`else
   localparam int LW = 7;
`endif
   localparam logic [LW-1:0] SEED = '1;

   logic [31:0]   cnt;
   logic [31:0]   div_max;
   logic          tick;
   logic          fb;
   logic [LW-1:0] lfsr;
   logic [LW-1:0] lfsr_next;

   // Compare with >= so that lowering user_freq below the running count ticks at once.
   always_comb begin
      div_max   = (user_freq <= 32'd1) ? 32'd0 : user_freq - 32'd1;
      tick      = (cnt >= div_max);
      fb        = lfsr[LW-1] ^ lfsr[LW-2];
      lfsr_next = (lfsr == '0) ? SEED : {lfsr[LW-2:0], fb};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= 32'd0;
         lfsr         <= SEED;
         signal_out   <= 1'b0;
         signal_cycle <= 1'b0;
      end else begin
         cnt          <= tick ? 32'd0 : cnt + 32'd1;
         signal_cycle <= tick && (lfsr_next == SEED);
         if (tick) begin
            signal_out <= lfsr[LW-1];
            lfsr       <= lfsr_next;
         end
      end
   end

endmodule

// File: tb/tb_prbs_random_generator.sv
// Directed test of prbs_random_generator (default PRBS-7 build) with hand-computed vectors.
module tb_prbs_random_generator;

   logic        clk;
   logic        reset;
   logic [31:0] user_freq;
   logic        signal_out;
   logic        signal_cycle;

   int vectors     = 0;
   int miscompares = 0;

   // Bits 1..21 of PRBS-7 from the all-ones seed, first bit in the MSB.
   logic [20:0] first21 = 21'b111111100000010000011;

   prbs_random_generator dut (
      .clk          (clk),
      .reset        (reset),
      .user_freq    (user_freq),
      .signal_out   (signal_out),
      .signal_cycle (signal_cycle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply_reset(input logic [31:0] freq);
      reset     = 1'b1;
      user_freq = freq;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_full_period(input string tag);
      int ones;
      int pulses;
      int pulse_edge;
      ones = 0;
      pulses = 0;
      pulse_edge = -1;
      for (int e = 1; e <= 128; e++) begin
         @(posedge clk);
         #1;
         if (e <= 21)
            chk($sformatf("%s_bit%0d", tag, e), {31'd0, signal_out}, {31'd0, first21[21-e]});
         if (e <= 127 && signal_out === 1'b1) ones++;
         if (signal_cycle === 1'b1) begin
            pulses++;
            pulse_edge = e;
         end
      end
      chk({tag, "_ones"}, ones, 64);
      chk({tag, "_pulses"}, pulses, 1);
      chk({tag, "_pulse_edge"}, pulse_edge, 127);
      chk({tag, "_bit128"}, {31'd0, signal_out}, 32'd1);
   endtask

   initial begin
      int transitions;
      int pulses;
      logic prev;

      reset     = 1'b1;
      user_freq = 32'd1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", {31'd0, signal_out}, 32'd0);
      chk("rst_cycle", {31'd0, signal_cycle}, 32'd0);

      // Full-rate period with user_freq 1, then 0.
      apply_reset(32'd1);
      run_full_period("f1");
      apply_reset(32'd0);
      run_full_period("f0");

      // Slow rate: ticks at edges 3000, 6000, ...; bit 8 (first 0) lands on edge 24000.
      apply_reset(32'd3000);
      transitions = 0;
      pulses = 0;
      prev = 1'b0;
      for (int e = 1; e <= 24000; e++) begin
         @(posedge clk);
         #1;
         if (signal_out !== prev) transitions++;
         prev = signal_out;
         if (signal_cycle === 1'b1) pulses++;
         if (e == 2999)  chk("slow_e2999",  {31'd0, signal_out}, 32'd0);
         if (e == 3000)  chk("slow_e3000",  {31'd0, signal_out}, 32'd1);
         if (e == 23999) chk("slow_e23999", {31'd0, signal_out}, 32'd1);
         if (e == 24000) chk("slow_e24000", {31'd0, signal_out}, 32'd0);
      end
      chk("slow_transitions", transitions, 2);
      chk("slow_pulses", pulses, 0);

      // Lowering the divider below the running count ticks on the next edge.
      apply_reset(32'd3000);
      repeat (2000) @(posedge clk);
      #1;
      chk("chg_before", {31'd0, signal_out}, 32'd0);
      user_freq = 32'd10;
      @(posedge clk);
      #1;
      chk("chg_immediate_tick", {31'd0, signal_out}, 32'd1);
      repeat (69) @(posedge clk);
      #1;
      chk("chg_e2070", {31'd0, signal_out}, 32'd1);
      @(posedge clk);
      #1;
      chk("chg_e2071_tick8", {31'd0, signal_out}, 32'd0);

      // Asynchronous reset after tick 50 (bit 50 is a 1), then restart from the seed.
      apply_reset(32'd1);
      repeat (50) @(posedge clk);
      #1;
      chk("mid_bit50", {31'd0, signal_out}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_async_out", {31'd0, signal_out}, 32'd0);
      chk("mid_async_cycle", {31'd0, signal_cycle}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("restart_bit%0d", e), {31'd0, signal_out}, {31'd0, first21[21-e]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
